// File: rtl/usb_tx_crc_framer_pkg.sv
// Shared definitions for the USB transmit framer: FSM states, PID codes,
// CRC16 constants and the per-byte CRC16 update step.
package usb_tx_crc_framer_pkg;

   typedef enum logic [2:0] {
      ST_IDLE,
      ST_PID,
      ST_DATA,
      ST_CRC_LO,
      ST_CRC_HI,
      ST_DONE
   } state_t;

   localparam logic [3:0]  DATA0       = 4'h3;
   localparam logic [3:0]  DATA1       = 4'hB;
   localparam logic [15:0] CRC_INIT    = 16'hFFFF;
   localparam logic [15:0] CRC_POLY_R  = 16'hA001;
   localparam logic [15:0] CRC_RESIDUE = 16'h800D;

   // Register is kept bit-reflected: bytes enter LSB first, as on the wire.
   function automatic logic [15:0] crc16_step(input logic [15:0] r, input logic [7:0] d);
      logic [15:0] x;
      x = r;
      for (int unsigned i = 0; i < 8; i++) begin
         if (x[0] ^ d[i]) x = (x >> 1) ^ CRC_POLY_R;
         else             x = x >> 1;
      end
      return x;
   endfunction

endpackage

// File: rtl/usb_tx_crc_framer_if.sv
// Request, payload-in and framed-out handshake bundle of the transmit framer.
interface usb_tx_crc_framer_if;

   logic       start;
   logic [3:0] pid;
   logic       zlp;
   logic [7:0] in_d;
   logic       in_dv;
   logic       in_last;
   logic       in_rdy;
   logic [7:0] out_d;
   logic       out_dv;
   logic       out_last;
   logic       out_rdy;
   logic       busy;
   logic       len_err;

   modport slave (
      input  start, pid, zlp, in_d, in_dv, in_last, out_rdy,
      output in_rdy, out_d, out_dv, out_last, busy, len_err
   );

   modport master (
      output start, pid, zlp, in_d, in_dv, in_last, out_rdy,
      input  in_rdy, out_d, out_dv, out_last, busy, len_err
   );

endinterface

// File: rtl/usb_tx_crc_framer_crc16.sv
// USB CRC16 datapath: synchronous clear to all-ones, one byte per dv,
// output presented inverted in the reflected (wire-order) form.
module usb_crc16
   import usb_tx_crc_framer_pkg::*;
(
   input  logic        c,
   input  logic        rst_n,
   input  logic        clr,
   input  logic        dv,
   input  logic [7:0]  d,
   output logic [15:0] crc
);

   logic [15:0] r;

   always_ff @(posedge c or negedge rst_n) begin
      if (!rst_n)  r <= CRC_INIT;
      else if (clr) r <= CRC_INIT;
      else if (dv)  r <= crc16_step(r, d);
   end

   assign crc = ~r;

endmodule

// File: rtl/usb_tx_crc_framer.sv
// Transmit framer: PID, payload, CRC16 low/high, with one output register
// slot and valid/ready flow control on both sides.
module usb_tx_crc_framer
   import usb_tx_crc_framer_pkg::*;
#(
   parameter int MAX_LEN = 1023,
   parameter int LEN_W   = 11
) (
   input  logic               c,
   input  logic               rst_n,
   usb_tx_crc_framer_if.slave bus
);

   state_t           state;
   logic [3:0]       pid_q;
   logic             zlp_q;
   logic [LEN_W-1:0] cnt;
   logic [15:0]      crc;
   logic             slot_free;
   logic             take;
   logic             crc_clr;
   logic             at_max;

   assign slot_free  = !bus.out_dv || bus.out_rdy;
   assign bus.in_rdy = (state == ST_DATA) && slot_free;
   assign take       = bus.in_dv && bus.in_rdy;
   assign crc_clr    = (state == ST_IDLE) && bus.start;
   assign at_max     = (cnt + LEN_W'(1)) == LEN_W'(MAX_LEN);

   usb_crc16 u_crc (
      .c     (c),
      .rst_n (rst_n),
      .clr   (crc_clr),
      .dv    (take),
      .d     (bus.in_d),
      .crc   (crc)
   );

   always_ff @(posedge c or negedge rst_n) begin
      if (!rst_n) begin
         state        <= ST_IDLE;
         pid_q        <= '0;
         zlp_q        <= 1'b0;
         cnt          <= '0;
         bus.out_d    <= '0;
         bus.out_dv   <= 1'b0;
         bus.out_last <= 1'b0;
         bus.busy     <= 1'b0;
         bus.len_err  <= 1'b0;
      end else begin
         bus.len_err <= 1'b0;
         // A drained slot empties unless a state below reloads it this cycle.
         if (bus.out_dv && bus.out_rdy) begin
            bus.out_dv   <= 1'b0;
            bus.out_last <= 1'b0;
         end
         case (state)
            ST_IDLE: begin
               if (bus.start) begin
                  pid_q    <= bus.pid;
                  zlp_q    <= bus.zlp;
                  cnt      <= '0;
                  bus.busy <= 1'b1;
                  state    <= ST_PID;
               end
            end
            ST_PID: begin
               if (slot_free) begin
                  bus.out_d  <= {~pid_q, pid_q};
                  bus.out_dv <= 1'b1;
                  state      <= zlp_q ? ST_CRC_LO : ST_DATA;
               end
            end
            ST_DATA: begin
               if (take) begin
                  bus.out_d  <= bus.in_d;
                  bus.out_dv <= 1'b1;
                  cnt        <= cnt + LEN_W'(1);
                  if (bus.in_last || at_max) state <= ST_CRC_LO;
                  if (!bus.in_last && at_max) bus.len_err <= 1'b1;
               end
            end
            ST_CRC_LO: begin
               if (slot_free) begin
                  bus.out_d  <= crc[7:0];
                  bus.out_dv <= 1'b1;
                  state      <= ST_CRC_HI;
               end
            end
            ST_CRC_HI: begin
               if (slot_free) begin
                  bus.out_d    <= crc[15:8];
                  bus.out_dv   <= 1'b1;
                  bus.out_last <= 1'b1;
                  state        <= ST_DONE;
               end
            end
            ST_DONE: begin
               if (bus.out_dv && bus.out_rdy) begin
                  bus.busy <= 1'b0;
                  state    <= ST_IDLE;
               end
            end
            default: state <= ST_IDLE;
         endcase
      end
   end

endmodule
